uart_line_ctrl: RTL and testbench

Line-buffered echo controller sitting between the board-level top and the `uart` core's FIFO interface. It drains the receive FIFO into a DEPTH-byte line buffer until a carriage return arrives or the buffer fills, then replays the line into the transmit FIFO followed by CR LF. It owns `rd_uart`/`wr_uart` sequencing, so the `uart` core is never read or written by anything else while this block is instantiated.

---
 rtl/uart_line_ctrl_pkg.sv | 31 +++
 rtl/uart_line_buf.sv | 37 +++
 rtl/uart_line_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_line_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_line_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_line_ctrl_pkg
// Shared definitions for the line-buffered UART echo controller:
//   - state_t     : controller FSM states
//   - ASCII_CR/LF : line terminator bytes
//   - upcase()    : maps ASCII 'a'..'z' to 'A'..'Z', passes all else through
// -----------------------------------------------------------------------------
package uart_line_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RX,   // waiting for a byte in the receive FIFO
        S_POP,  // pop strobe is high; decide whether the line is complete
        S_TX,   // replaying buffered bytes
        S_TXW,  // one-cycle gap after a data push
        S_CR,   // push carriage return
        S_CRW,  // gap after CR push
        S_LF,   // push line feed
        S_LFW   // gap after LF push; line finished
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] upcase(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) begin
            return c - 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_line_buf.sv
// -----------------------------------------------------------------------------
// uart_line_buf
// DEPTH x 8 line buffer: one synchronous write port, one asynchronous read
// port. Contents are never cleared; the controller only reads entries it has
// written in the current line.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module uart_line_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_ctrl.sv
// -----------------------------------------------------------------------------
// uart_line_ctrl
// Line-buffered echo controller in front of a UART core's FIFO interface.
// Drains the receive FIFO into a DEPTH-byte line buffer until a CR arrives or
// the buffer fills, then replays the line into the transmit FIFO followed by
// CR LF. Every pop/push strobe is a single cycle followed by at least one idle
// cycle, so the FIFO flags have time to update before the next decision.
//
// Build option:
//   UART_LINE_CTRL_UPCASE_EN  when defined, 'a'..'z' are sent as 'A'..'Z'
//                             (buffer and led keep the original byte).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   rx_empty  in   receive FIFO empty
//   r_data    in   receive FIFO head byte (valid when rx_empty==0)
//   tx_full   in   transmit FIFO full
//   rd_uart   out  one-cycle pop strobe to the receive FIFO
//   wr_uart   out  one-cycle push strobe to the transmit FIFO
//   w_data    out  byte pushed while wr_uart==1
//   led       out  last byte popped (CR included)
//   busy      out  high while the line is being transmitted
// -----------------------------------------------------------------------------
module uart_line_ctrl
    import uart_line_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    input  logic       tx_full,
    output logic       rd_uart,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [7:0] led,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so count can represent a completely full line (== DEPTH).
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t          state_reg,   state_next;
    logic [CW-1:0]   count_reg,   count_next;
    logic [CW-1:0]   rd_ptr_reg,  rd_ptr_next;
    logic [7:0]      byte_reg,    byte_next;
    logic            rd_uart_reg, rd_uart_next;
    logic            wr_uart_reg, wr_uart_next;
    logic [7:0]      w_data_reg,  w_data_next;
    logic [7:0]      led_reg,     led_next;
    logic            busy_reg,    busy_next;

    logic            buf_we;
    logic [7:0]      buf_rdata;
    logic [7:0]      tx_byte;
    logic [CW-1:0]   count_inc;

    // -------------------------------------------------------------------------
    // Line buffer
    // -------------------------------------------------------------------------
    uart_line_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count_reg[AW-1:0]),
        .wdata (r_data),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (buf_rdata)
    );

`ifdef UART_LINE_CTRL_UPCASE_EN
    assign tx_byte = upcase(buf_rdata);
`else
    assign tx_byte = buf_rdata;
`endif

    assign count_inc = count_reg + CW'(1);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_RX;
            count_reg   <= '0;
            rd_ptr_reg  <= '0;
            byte_reg    <= 8'h00;
            rd_uart_reg <= 1'b0;
            wr_uart_reg <= 1'b0;
            w_data_reg  <= 8'h00;
            led_reg     <= 8'h00;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            rd_ptr_reg  <= rd_ptr_next;
            byte_reg    <= byte_next;
            rd_uart_reg <= rd_uart_next;
            wr_uart_reg <= wr_uart_next;
            w_data_reg  <= w_data_next;
            led_reg     <= led_next;
            busy_reg    <= busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Strobes default low so each is high for one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        rd_ptr_next  = rd_ptr_reg;
        byte_next    = byte_reg;
        rd_uart_next = 1'b0;
        wr_uart_next = 1'b0;
        w_data_next  = w_data_reg;
        led_next     = led_reg;
        busy_next    = busy_reg;
        buf_we       = 1'b0;

        case (state_reg)
            S_RX: begin
                if (!rx_empty) begin
                    led_next     = r_data;
                    byte_next    = r_data;
                    // The terminator itself is not stored in the line.
                    buf_we       = (r_data != ASCII_CR);
                    rd_uart_next = 1'b1;
                    state_next   = S_POP;
                end
            end

            S_POP: begin
                if (byte_reg == ASCII_CR) begin
                    rd_ptr_next = '0;
                    busy_next   = 1'b1;
                    state_next  = S_TX;
                end else begin
                    count_next = count_inc;
                    if (count_inc == DEPTH_C) begin
                        rd_ptr_next = '0;
                        busy_next   = 1'b1;
                        state_next  = S_TX;
                    end else begin
                        state_next = S_RX;
                    end
                end
            end

            S_TX: begin
                if (rd_ptr_reg == count_reg) begin
                    state_next = S_CR;
                end else if (!tx_full) begin
                    w_data_next  = tx_byte;
                    wr_uart_next = 1'b1;
                    rd_ptr_next  = rd_ptr_reg + CW'(1);
                    state_next   = S_TXW;
                end
            end

            S_TXW: begin
                state_next = S_TX;
            end

            S_CR: begin
                if (!tx_full) begin
                    w_data_next  = ASCII_CR;
                    wr_uart_next = 1'b1;
                    state_next   = S_CRW;
                end
            end

            S_CRW: begin
                state_next = S_LF;
            end

            S_LF: begin
                if (!tx_full) begin
                    w_data_next  = ASCII_LF;
                    wr_uart_next = 1'b1;
                    state_next   = S_LFW;
                end
            end

            S_LFW: begin
                count_next  = '0;
                rd_ptr_next = '0;
                busy_next   = 1'b0;
                state_next  = S_RX;
            end

            default: begin
                state_next = S_RX;
            end
        endcase
    end

    assign rd_uart = rd_uart_reg;
    assign wr_uart = wr_uart_reg;
    assign w_data  = w_data_reg;
    assign led     = led_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_uart_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_line_ctrl
// Directed bench for uart_line_ctrl (DEPTH=16). A receive-FIFO model feeds
// bytes and pops on rd_uart; a transmit log captures w_data on wr_uart.
// Inputs change 2 time units after a rising edge; the FIFO model and the
// protocol monitor act on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_line_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] led;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Receive FIFO model: stimulus writes rx_src/rx_wr, monitor advances rx_rd.
    logic [7:0] rx_src [0:63];
    int         rx_wr = 0;
    int         rx_rd = 0;

    // Transmit log: monitor writes tx_log/tx_cnt, stimulus reads.
    logic [7:0] tx_log [0:127];
    int         tx_cnt  = 0;
    int         tx_base = 0;

    // Protocol monitor state.
    int   mon_viol     = 0;
    logic prev_rd      = 1'b0;
    logic prev_wr      = 1'b0;
    logic seen_rx_empty = 1'b1;
    logic seen_tx_full  = 1'b0;

    always #5 clk = ~clk;

    uart_line_ctrl #(
        .DEPTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .tx_full  (tx_full),
        .rd_uart  (rd_uart),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .led      (led),
        .busy     (busy)
    );

    // FIFO models and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rd_uart) begin
            if (wr_uart)       mon_viol = mon_viol + 1;
            if (seen_rx_empty) mon_viol = mon_viol + 1;
            if (prev_rd)       mon_viol = mon_viol + 1;
            if (busy)          mon_viol = mon_viol + 1;
        end
        if (wr_uart) begin
            if (seen_tx_full)  mon_viol = mon_viol + 1;
            if (prev_wr)       mon_viol = mon_viol + 1;
            tx_log[tx_cnt] = w_data;
            tx_cnt = tx_cnt + 1;
        end
        prev_rd = rd_uart;
        prev_wr = wr_uart;
        if (rd_uart && (rx_rd != rx_wr)) rx_rd = rx_rd + 1;
        rx_empty = (rx_rd == rx_wr);
        r_data   = rx_empty ? 8'h00 : rx_src[rx_rd];
        seen_rx_empty = rx_empty;
        seen_tx_full  = tx_full;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_src[rx_wr] = b;
        rx_wr = rx_wr + 1;
    endtask

    // Wait (bounded) for n bytes since tx_base, settle, then check exact count.
    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while ((tx_cnt - tx_base) < n && k < 400) begin
            step(1);
            k++;
        end
        step(12);
        chk(tag, 32'(tx_cnt - tx_base), 32'(n));
    endtask

    task automatic exp_tx(input string tag, input int idx, input logic [7:0] val);
        chk(tag, 32'(tx_log[tx_base + idx]), 32'(val));
    endtask

    function automatic logic [7:0] tb_up(input logic [7:0] c);
`ifdef UART_LINE_CTRL_UPCASE_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    initial begin
        int k;

        // ---- Reset state ----
        reset = 1'b0;
        step(3);
        chk("rst_rd_uart", 32'(rd_uart), 32'd0);
        chk("rst_wr_uart", 32'(wr_uart), 32'd0);
        chk("rst_w_data",  32'(w_data),  32'h00);
        chk("rst_led",     32'(led),     32'h00);
        chk("rst_busy",    32'(busy),    32'd0);
        reset = 1'b1;
        step(2);

        // ---- Test 1: "ab\r" ----
        push_rx(8'h61); push_rx(8'h62); push_rx(8'h0D);
        wait_tx("t1_count", 4);
        exp_tx("t1_b0", 0, tb_up(8'h61));
        exp_tx("t1_b1", 1, tb_up(8'h62));
        exp_tx("t1_cr", 2, 8'h0D);
        exp_tx("t1_lf", 3, 8'h0A);
        chk("t1_led",  32'(led),  32'h0D);
        chk("t1_busy", 32'(busy), 32'd0);
        $display("txn t1 ab-CR tx_count=%0d led=%02h", tx_cnt - tx_base, led);
        tx_base = tx_cnt;

        // ---- Test 2: empty line ----
        push_rx(8'h0D);
        wait_tx("t2_count", 2);
        exp_tx("t2_cr", 0, 8'h0D);
        exp_tx("t2_lf", 1, 8'h0A);
        $display("txn t2 empty-line tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;

        // ---- Test 3: full line of 16 bytes, 17th waits ----
        for (int i = 0; i < 16; i++) push_rx(8'(8'h30 + i));
        push_rx(8'h40);
        k = 0;
        while (!busy && k < 200) begin step(1); k++; end
        chk("t3_busy_rise", 32'(busy), 32'd1);
        chk("t3_pending_at_tx", 32'(rx_wr - rx_rd), 32'd1);
        k = 0;
        while (busy && k < 400) begin step(1); k++; end
        chk("t3_busy_fall", 32'(busy), 32'd0);
        chk("t3_pending_after_tx", 32'(rx_wr - rx_rd), 32'd1);
        wait_tx("t3_count", 18);
        for (int i = 0; i < 16; i++) exp_tx("t3_data", i, 8'(8'h30 + i));
        exp_tx("t3_cr", 16, 8'h0D);
        exp_tx("t3_lf", 17, 8'h0A);
        $display("txn t3 full-line tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;
        push_rx(8'h0D);
        wait_tx("t3b_count", 3);
        exp_tx("t3b_b0", 0, 8'h40);
        exp_tx("t3b_cr", 1, 8'h0D);
        exp_tx("t3b_lf", 2, 8'h0A);
        $display("txn t3b carry-over tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;

        // ---- Test 4: tx_full stall mid-line ----
        push_rx(8'h31); push_rx(8'h32); push_rx(8'h33); push_rx(8'h34); push_rx(8'h0D);
        k = 0;
        while ((tx_cnt - tx_base) < 1 && k < 200) begin step(1); k++; end
        tx_full = 1'b1;
        step(20);
        chk("t4_stalled_count", 32'(tx_cnt - tx_base), 32'd1);
        chk("t4_stalled_wr", 32'(wr_uart), 32'd0);
        tx_full = 1'b0;
        wait_tx("t4_count", 6);
        for (int i = 0; i < 4; i++) exp_tx("t4_data", i, 8'(8'h31 + i));
        exp_tx("t4_cr", 4, 8'h0D);
        exp_tx("t4_lf", 5, 8'h0A);
        $display("txn t4 stall tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;

        // ---- Test 5: reset during transmit after 2 of 5 bytes ----
        push_rx(8'h68); push_rx(8'h65); push_rx(8'h6C); push_rx(8'h6C); push_rx(8'h6F);
        push_rx(8'h0D);
        k = 0;
        while ((tx_cnt - tx_base) < 2 && k < 300) begin step(1); k++; end
        reset = 1'b0;
        step(1);
        chk("t5_rd_uart", 32'(rd_uart), 32'd0);
        chk("t5_wr_uart", 32'(wr_uart), 32'd0);
        chk("t5_busy",    32'(busy),    32'd0);
        chk("t5_led",     32'(led),     32'h00);
        reset = 1'b1;
        step(10);
        chk("t5_abandoned_count", 32'(tx_cnt - tx_base), 32'd2);
        exp_tx("t5_b0", 0, tb_up(8'h68));
        exp_tx("t5_b1", 1, tb_up(8'h65));
        $display("txn t5 reset-mid-tx tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;
        push_rx(8'h78); push_rx(8'h0D);
        wait_tx("t5b_count", 3);
        exp_tx("t5b_b0", 0, tb_up(8'h78));
        exp_tx("t5b_cr", 1, 8'h0D);
        exp_tx("t5b_lf", 2, 8'h0A);
        chk("t5b_led", 32'(led), 32'h0D);
        $display("txn t5b x-CR tx_count=%0d", tx_cnt - tx_base);
        tx_base = tx_cnt;

        // ---- Protocol monitor result ----
        chk("protocol_violations", 32'(mon_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
